// File: rtl/id_ex_skid_latch.sv
// ID->EX pipeline latch: valid/ready handshake with a 2-entry skid buffer and synchronous flush.
// Optional stall counter output enabled by defining ID_EX_STALL_CNT_EN.
module id_ex_skid_latch #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
`ifdef ID_EX_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rdata1,
    input  logic [DATA_W-1:0] in_rdata2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_alusrc,
    input  logic [OP_W-1:0]   in_aluop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata1,
    output logic [DATA_W-1:0] out_rdata2,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_alusrc,
    output logic [OP_W-1:0]   out_aluop
);

    typedef struct packed {
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rd;
        logic              alusrc;
        logic [OP_W-1:0]   aluop;
    } beat_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    beat_t  out_q;
    beat_t  skid_q;
    logic   out_valid_q;
    logic   skid_valid_q;
    beat_t  in_beat;
    logic   in_fire;
    logic   out_fire;

    assign in_beat = '{rdata1: in_rdata1, rdata2: in_rdata2, imm: in_imm,
                       rd: in_rd, alusrc: in_alusrc, aluop: in_aluop};

    // Ready comes straight from the skid flop, so EX back-pressure never reaches ID combinationally.
    assign in_ready = ~skid_valid_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    // NOTE: all state in this block uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            // Only the valid bits are dropped; data registers keep their stale contents.
            state_q      <= EMPTY;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        out_q       <= in_beat;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_q <= in_beat;
                    end else if (in_fire) begin
                        skid_q       <= in_beat;
                        skid_valid_q <= 1'b1;
                        state_q      <= FULL;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_q        <= skid_q;
                        skid_valid_q <= 1'b0;
                        state_q      <= ONE;
                    end
                end
                default: begin
                    state_q      <= EMPTY;
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_rdata1 = out_q.rdata1;
    assign out_rdata2 = out_q.rdata2;
    assign out_imm    = out_q.imm;
    assign out_rd     = out_q.rd;
    assign out_alusrc = out_q.alusrc;
    assign out_aluop  = out_q.aluop;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles EX holds off a valid beat; flush deliberately leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_latch.sv
// Self-checking bench for id_ex_skid_latch: directed steps plus random traffic checked against a
// depth-2 FIFO reference model with one-cycle latency.
module tb_id_ex_skid_latch;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int OP_W   = 2;

    typedef struct packed {
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rd;
        logic              alusrc;
        logic [OP_W-1:0]   aluop;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_rdata1;
    logic [DATA_W-1:0] in_rdata2;
    logic [DATA_W-1:0] in_imm;
    logic [REG_W-1:0]  in_rd;
    logic              in_alusrc;
    logic [OP_W-1:0]   in_aluop;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rdata1;
    logic [DATA_W-1:0] out_rdata2;
    logic [DATA_W-1:0] out_imm;
    logic [REG_W-1:0]  out_rd;
    logic              out_alusrc;
    logic [OP_W-1:0]   out_aluop;
`ifdef ID_EX_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    id_ex_skid_latch #(
        .DATA_W(DATA_W),
        .REG_W (REG_W),
        .OP_W  (OP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
`ifdef ID_EX_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rdata1 (in_rdata1),
        .in_rdata2 (in_rdata2),
        .in_imm    (in_imm),
        .in_rd     (in_rd),
        .in_alusrc (in_alusrc),
        .in_aluop  (in_aluop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rdata1(out_rdata1),
        .out_rdata2(out_rdata2),
        .out_imm   (out_imm),
        .out_rd    (out_rd),
        .out_alusrc(out_alusrc),
        .out_aluop (out_aluop)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: accepted beats queue up (at most two), the head is what EX sees.
    beat_t       mq[$];
    beat_t       m_shown = '0;
    logic [31:0] m_stall = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
        check({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
        check({tag, ".rdata1"},    64'(out_rdata1), 64'(m_shown.rdata1));
        check({tag, ".rdata2"},    64'(out_rdata2), 64'(m_shown.rdata2));
        check({tag, ".imm"},       64'(out_imm),    64'(m_shown.imm));
        check({tag, ".rd"},        64'(out_rd),     64'(m_shown.rd));
        check({tag, ".alusrc"},    64'(out_alusrc), 64'(m_shown.alusrc));
        check({tag, ".aluop"},     64'(out_aluop),  64'(m_shown.aluop));
`ifdef ID_EX_STALL_CNT_EN
        check({tag, ".stall_cnt"}, 64'(stall_cnt),  64'(m_stall));
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare away from the edge.
    task automatic step(input string tag, input logic v, input logic ordy, input logic fl,
                        input logic r, input beat_t b);
        bit acc;
        bit emit;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        in_rdata1 = b.rdata1;
        in_rdata2 = b.rdata2;
        in_imm    = b.imm;
        in_rd     = b.rd;
        in_alusrc = b.alusrc;
        in_aluop  = b.aluop;
        @(posedge clk);
        acc  = v && (mq.size() < 2);
        emit = (mq.size() > 0) && ordy;
        if (r)
            m_stall = '0;
        else if ((mq.size() > 0) && !ordy && (m_stall != 32'hFFFF_FFFF))
            m_stall = m_stall + 1;
        if (r || fl) begin
            mq.delete();
        end else begin
            if (emit) void'(mq.pop_front());
            if (acc) mq.push_back(b);
        end
        if (r)
            m_shown = '0;
        else if (mq.size() > 0)
            m_shown = mq[0];
        #1;
        check_all(tag);
    endtask

    function automatic beat_t mk(input logic [31:0] r2, input logic [31:0] im,
                                 input logic [4:0] rd, input logic src);
        beat_t b;
        b.rdata1 = 32'h1000_0000 + 32'(rd);
        b.rdata2 = r2;
        b.imm    = im;
        b.rd     = rd;
        b.alusrc = src;
        b.aluop  = rd[1:0];
        return b;
    endfunction

    function automatic beat_t rnd();
        beat_t b;
        b.rdata1 = $urandom;
        b.rdata2 = $urandom;
        b.imm    = $urandom;
        b.rd     = 5'($urandom);
        b.alusrc = 1'($urandom);
        b.aluop  = 2'($urandom);
        return b;
    endfunction

    initial begin
        beat_t z;
        z = '0;
        in_valid = 0; out_ready = 0; flush = 0; rst = 1;
        in_rdata1 = '0; in_rdata2 = '0; in_imm = '0; in_rd = '0; in_alusrc = 0; in_aluop = '0;

        // Reset, with a beat presented that must not be captured.
        step("rst0", 1'b1, 1'b0, 1'b0, 1'b1, mk(32'hDEAD, 32'hBEEF, 5'd9, 1'b1));
        step("rst1", 1'b0, 1'b0, 1'b0, 1'b1, z);
        step("idle", 1'b0, 1'b1, 1'b0, 1'b0, z);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);

        // Single beat, one-cycle latency, gone the cycle after.
        step("single", 1'b1, 1'b1, 1'b0, 1'b0, mk(32'h0000_00AA, 32'h0000_0010, 5'd1, 1'b1));
        check("single.rdata2", 64'(out_rdata2), 64'h0000_00AA);
        check("single.imm", 64'(out_imm), 64'h0000_0010);
        step("single_gone", 1'b0, 1'b1, 1'b0, 1'b0, z);

        // Back-pressure: A then B fill both entries, then drain in order.
        step("bp_a", 1'b1, 1'b0, 1'b0, 1'b0, mk(32'hA, 32'hA0, 5'd3, 1'b0));
        step("bp_b", 1'b1, 1'b0, 1'b0, 1'b0, mk(32'hB, 32'hB0, 5'd4, 1'b1));
        check("bp.in_ready_low", 64'(in_ready), 64'd0);
        step("bp_hold", 1'b1, 1'b0, 1'b0, 1'b0, mk(32'hE, 32'hE0, 5'd30, 1'b0));
        check("bp.hold_rd", 64'(out_rd), 64'd3);
        step("bp_drain_a", 1'b0, 1'b1, 1'b0, 1'b0, z);
        check("bp.second_rd", 64'(out_rd), 64'd4);
        step("bp_drain_b", 1'b0, 1'b1, 1'b0, 1'b0, z);

        // Streaming: eight back-to-back beats with EX always ready.
        for (int i = 0; i < 8; i++)
            step($sformatf("stream%0d", i), 1'b1, 1'b1, 1'b0, 1'b0,
                 mk($urandom, $urandom, 5'(i), 1'($urandom)));
        step("stream_end", 1'b0, 1'b1, 1'b0, 1'b0, z);

        // Flush while FULL and presenting C; C must never appear.
        step("fl_a", 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h1, 32'h1, 5'd10, 1'b0));
        step("fl_b", 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h2, 32'h2, 5'd11, 1'b0));
        step("fl_c", 1'b1, 1'b0, 1'b1, 1'b0, mk(32'h3, 32'h3, 5'd12, 1'b1));
        check("flush.out_valid", 64'(out_valid), 64'd0);
        check("flush.in_ready", 64'(in_ready), 64'd1);
        step("fl_after", 1'b0, 1'b1, 1'b0, 1'b0, z);

        // Flush in ONE while a beat is accepted: the incoming beat is dropped too.
        step("fl1_a", 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h4, 32'h4, 5'd13, 1'b0));
        step("fl1_b", 1'b1, 1'b1, 1'b1, 1'b0, mk(32'h5, 32'h5, 5'd14, 1'b0));
        step("fl1_after", 1'b0, 1'b1, 1'b0, 1'b0, z);

        // Reset asserted together with flush while FULL.
        step("rf_a", 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h6, 32'h6, 5'd15, 1'b1));
        step("rf_b", 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h7, 32'h7, 5'd16, 1'b1));
        step("rf_rst", 1'b1, 1'b0, 1'b1, 1'b1, mk(32'h8, 32'h8, 5'd17, 1'b1));
        check("rstflush.rdata2", 64'(out_rdata2), 64'd0);
        step("rf_after", 1'b0, 1'b1, 1'b0, 1'b0, z);

`ifdef ID_EX_STALL_CNT_EN
        // Stall counter: five stalled cycles, survives flush, cleared by reset.
        step("sc_load", 1'b1, 1'b0, 1'b0, 1'b0, mk(32'h9, 32'h9, 5'd18, 1'b0));
        for (int i = 0; i < 5; i++)
            step($sformatf("sc_stall%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, z);
        check("stall.five", 64'(stall_cnt), 64'd5);
        step("sc_flush", 1'b0, 1'b1, 1'b1, 1'b0, z);
        check("stall.after_flush", 64'(stall_cnt), 64'd5);
        step("sc_rst", 1'b0, 1'b0, 1'b0, 1'b1, z);
        check("stall.after_rst", 64'(stall_cnt), 64'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0),
                 1'($urandom_range(0, 99) == 0), rnd());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
